// File: rtl/mult_div_sequencer.sv
// Multi-cycle signed multiply/divide engine. It runs a shift-add multiply or a
// restoring divide on the operand magnitudes, then fixes up the signs of HI/LO.
module mult_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_CALC   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               op_q, op_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d, done_q, done_d, div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;
    logic [2*WIDTH-1:0] mul_acc, div_acc, calc_acc, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;

    assign mag_a = a_q[WIDTH-1] ? -a_q : a_q;
    assign mag_b = b_q[WIDTH-1] ? -b_q : b_q;

    // Multiply: low half of acc holds the multiplier and shifts out LSB first.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: high half is the partial remainder, low half the dividend/quotient.
    assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, m_q};
    assign div_acc  = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign calc_acc = op_q ? div_acc : mul_acc;
    assign prod_s   = (sa_q ^ sb_q) ? -calc_acc : calc_acc;
    assign quo_s    = (sa_q ^ sb_q) ? -calc_acc[WIDTH-1:0] : calc_acc[WIDTH-1:0];
    assign rem_s    = sa_q ? -calc_acc[2*WIDTH-1:WIDTH] : calc_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        div0_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = operand_a;
                    b_d     = operand_b;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                sa_d  = a_q[WIDTH-1];
                sb_d  = b_q[WIDTH-1];
                cnt_d = '0;
                acc_d = op_q ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                m_d   = op_q ? mag_b : mag_a;
                if (op_q && (b_q == '0)) begin
                    done_d  = 1'b1;
                    div0_d  = 1'b1;
                    state_d = S_RESULT;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                acc_d = calc_acc;
                cnt_d = cnt_q + 1'b1;
                // Final iteration folds straight into the registered result.
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    done_d  = 1'b1;
                    state_d = S_RESULT;
                    if (op_q) begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end else begin
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                        lo_d = prod_s[WIDTH-1:0];
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: latency, signed results, div0 and reset abort.
module tb_mult_div_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op    = 1'b0;
    logic [31:0] operand_a = '0;
    logic [31:0] operand_b = '0;
    logic        busy, done, div0;
    logic [31:0] hi, lo;
    int          total = 0;
    int          bad   = 0;

    mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one op from IDLE (called 1 time unit after an edge); returns the
    // edge index at which done was seen and whether busy stayed high until then.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output int n, output logic busy_ok);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        step();
        start = 1'b0; op = ~o; operand_a = 32'hDEADBEEF; operand_b = 32'h0BADF00D;
        n = 1;
        busy_ok = busy;
        while (!done && n < 100) begin
            step();
            n++;
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int n;
        logic bok;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        step();
        reset = 1'b1;
        step();

        // 1: MULT 7 * -3
        run_op(1'b0, 32'd7, 32'hFFFFFFFD, n, bok);
        chk("t1_lat", n, 34);
        chk("t1_busy", bok, 1);
        chk("t1_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        chk("t1_div0", div0, 0);
        step();
        chk("t1_done_fall", done, 0);
        chk("t1_busy_fall", busy, 0);

        // 2: MULT corner magnitudes
        run_op(1'b0, 32'h80000000, 32'h80000000, n, bok);
        chk("t2a_hilo", {hi, lo}, 64'h40000000_00000000);
        step();
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, n, bok);
        chk("t2b_hilo", {hi, lo}, 64'h00000000_00000001);
        step();

        // 3: signed DIV, truncating
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, n, bok);
        chk("t3a_lat", n, 34);
        chk("t3a_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        step();
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, n, bok);
        chk("t3b_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);
        step();
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, n, bok);
        chk("t3c_hilo", {hi, lo}, 64'h00000000_80000000);
        chk("t3c_div0", div0, 0);
        step();

        // 4: div-by-zero keeps hi/lo
        run_op(1'b0, 32'd3, 32'd5, n, bok);
        chk("t4_pre", {hi, lo}, 64'h00000000_0000000F);
        step();
        run_op(1'b1, 32'd5, 32'd0, n, bok);
        chk("t4_lat", n, 2);
        chk("t4_div0", div0, 1);
        chk("t4_hilo", {hi, lo}, 64'h00000000_0000000F);
        step();
        chk("t4_pulse", {done, div0, busy}, 3'b000);
        run_op(1'b1, 32'd9, 32'd4, n, bok);
        chk("t4_div", {hi, lo}, 64'h00000001_00000002);
        chk("t4_div0_clr", div0, 0);
        step();

        // 5: start ignored while busy, accepted right after
        start = 1'b1; op = 1'b0; operand_a = 32'd6; operand_b = 32'd7;
        n = 0;
        begin
            logic seen_done;
            seen_done = 1'b0;
            for (int k = 1; k <= 35; k++) begin
                step();
                if (k == 4 || k == 33) begin
                    start = 1'b1; op = 1'b1; operand_a = 32'd100; operand_b = 32'd3;
                end else begin
                    start = 1'b0;
                end
                if (done) begin
                    seen_done = 1'b1;
                    n = k;
                end
            end
            chk("t5_seen", seen_done, 1);
        end
        chk("t5_lat", n, 34);
        chk("t5_hilo", {hi, lo}, 64'h00000000_0000002A);
        chk("t5_idle", busy, 0);
        run_op(1'b0, 32'd4, 32'd5, n, bok);
        chk("t5_b2b_lat", n, 34);
        chk("t5_b2b", {hi, lo}, 64'h00000000_00000014);
        step();

        // 6: async reset mid-DIV
        start = 1'b1; op = 1'b1; operand_a = 32'd100; operand_b = 32'd7;
        step();
        start = 1'b0;
        for (int k = 2; k <= 10; k++) step();
        chk("t6_busy_pre", busy, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_flags", {busy, done, div0}, 3'b000);
        chk("t6_rst_hilo", {hi, lo}, 64'h0);
        begin
            logic stray;
            stray = 1'b0;
            for (int k = 0; k < 40; k++) begin
                step();
                if (k == 3) reset = 1'b1;
                if (done) stray = 1'b1;
            end
            chk("t6_no_done", stray, 0);
        end
        run_op(1'b0, 32'd2, 32'd3, n, bok);
        chk("t6_lat", n, 34);
        chk("t6_hilo", {hi, lo}, 64'h00000000_00000006);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
Multi-cycle signed multiply/divide engine with its own sequencing FSM. It sits beside the ALU and is started by the main control unit in its MULT_LOAD/DIV_LOAD states. It produces the HI/LO results that MFHI/MFLO read, and it raises the div0 exception flag. It replaces any single-cycle mult/div, so the control unit only issues start and waits for done.

Parameters:
WIDTH, 32, operand width; also the number of CALC iterations.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
start  in  1  request; sampled only in IDLE.
op  in  1  0 = MULT, 1 = DIV; sampled with start.
operand_a  in  WIDTH  rs value: multiplicand or dividend, signed.
operand_b  in  WIDTH  rt value: multiplier or divisor, signed.
busy  out  1  high in LOAD, CALC and RESULT.
done  out  1  one-cycle completion pulse.
div0  out  1  high only in the done cycle of a DIV whose divisor is 0.
hi  out  WIDTH  MULT: product[2*WIDTH-1:WIDTH]. DIV: remainder.
lo  out  WIDTH  MULT: product[WIDTH-1:0]. DIV: quotient.

Behaviour:
- All outputs are registered.
- Reset asserted (at any time, including mid-operation): state = IDLE, counter = 0, busy/done/div0 = 0, hi/lo = 0. Any operation in flight is abandoned with no done pulse.
- States:
  - IDLE: if start = 1, latch op, operand_a, operand_b, go to LOAD. Otherwise stay.
  - LOAD: record sign_a, sign_b and the magnitudes |a|, |b| as unsigned WIDTH-bit values (|0x80000000| = 0x80000000). Clear the accumulator and counter.
    - DIV with operand_b = 0: go to RESULT with div-by-zero flagged.
    - Otherwise go to CALC.
  - CALC: one iteration per cycle, counter 0..WIDTH-1. Go to RESULT on the cycle counter = WIDTH-1 completes.
    - MULT: unsigned shift-add on the magnitudes into a 2*WIDTH-bit accumulator.
    - DIV: restoring division on the magnitudes, one quotient bit per cycle, MSB first.
  - RESULT: update hi/lo, assert done for this cycle only, then go to IDLE.
    - MULT: if sign_a XOR sign_b, negate the 2*WIDTH-bit product.
    - DIV: negate the quotient if sign_a XOR sign_b; negate the remainder if sign_a. Remainder sign follows the dividend (truncating division).
    - Div-by-zero: div0 = 1 with done; hi/lo keep their previous values.
- Latency, counting from the edge that samples start:
  - Normal op: busy rises after edge 1; done and the new hi/lo are visible after edge WIDTH+2 (edge 34 for WIDTH = 32); busy falls after edge WIDTH+3.
  - Div-by-zero: done and div0 visible after edge 2.
- Handshake:
  - start is ignored while busy = 1, including in the RESULT cycle.
  - Back-to-back operations: start may be high in the first IDLE cycle after done.
  - Operands need only be valid in the start cycle.
- hi/lo hold their value between completions. They change only in RESULT for a non-div0 op, or on reset.
- Arithmetic:
  - The DIV overflow case 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0, div0 = 0, with no other flag.
  - MULT never overflows (full 2*WIDTH result).
- Unused opcodes are not this block's concern; op is a single bit.

Test Plan:
1. MULT a=7, b=0xFFFFFFFD (−3) -> done after edge 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for edges 1..34.
2. MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000. MULT a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0, lo=1.
3. DIV a=0xFFFFFFF9 (−7), b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIV a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Preload hi/lo via MULT 3×5 (lo=15), then DIV a=5, b=0 -> done and div0 high together after edge 2, single cycle; hi=0, lo=15 unchanged; next DIV 9/4 gives lo=2, hi=1 with div0=0.
5. start pulsed again with different operands at edges 5 and 34 of a running MULT 6×7 -> both ignored; result lo=42, hi=0. A start in the cycle after done is accepted.
6. Drive reset low at edge 10 of a DIV -> busy, done, div0, hi, lo go to 0 immediately (asynchronously); no done pulse. After release, MULT 2×3 completes with lo=6 at the normal latency.
